// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the pipeline processor
// that owns the instruction memory.
package imem_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } ld_state_e;

   localparam int unsigned IM_DW    = 16;
   localparam int unsigned IM_AW    = 16;
   localparam int unsigned IM_DEPTH = 1 << IM_AW;

   // Word-count check used by both the loader and any host-side sequencer.
   function automatic logic is_empty_load(input logic [IM_AW-1:0] count);
      return (count == '0);
   endfunction

endpackage

// File: rtl/imem_loader_ctrl.sv
// Loader control: IDLE/LOAD/DONE sequencing, handshake, processor hold and done pulse.
module imem_loader_ctrl
   import imem_loader_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic start_i,
   input  logic count_zero_i,
   input  logic last_word_i,
   input  logic in_valid_i,
   output logic in_ready_o,
   output logic xfer_o,
   output logic accept_o,
   output logic busy_o,
   output logic done_o,
   output logic cpu_hold_o
);

   ld_state_e state_q;
   logic      ready_q;
   logic      busy_q;
   logic      done_q;
   logic      hold_q;
   logic      loaded_q;

   // Handshake is masked during reset so the source never sees a word taken
   // that the memory did not receive.
   assign in_ready_o = ready_q & ~rst_i;
   assign xfer_o     = in_ready_o & in_valid_i;
   assign accept_o   = (state_q == ST_IDLE) & start_i & ~rst_i;

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign cpu_hold_o = hold_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         hold_q   <= 1'b1;
         loaded_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  busy_q <= 1'b1;
                  hold_q <= 1'b1;
                  if (count_zero_i) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_LOAD;
                     ready_q <= 1'b1;
                  end
               end else begin
                  hold_q <= ~loaded_q;
               end
            end
            ST_LOAD: begin
               if (xfer_o && last_word_i) begin
                  state_q <= ST_DONE;
                  ready_q <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            ST_DONE: begin
               state_q  <= ST_IDLE;
               done_q   <= 1'b0;
               busy_q   <= 1'b0;
               hold_q   <= 1'b0;
               loaded_q <= 1'b1;
            end
            default: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               hold_q  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Streams program words into the processor instruction memory while holding the CPU,
// tracking write address, words remaining and a running checksum.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DW = IM_DW,
   parameter int AW = IM_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [AW-1:0] word_count,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic          im_we,
   output logic [AW-1:0] im_addr,
   output logic [DW-1:0] im_wdata,
   output logic          cpu_hold,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] checksum
);

   logic          accept;
   logic          xfer;
   logic          count_zero;
   logic          last_word;

   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] rem_q,  rem_d;
   logic [DW-1:0] csum_q, csum_d;

   assign count_zero = (word_count == '0);
   assign last_word  = (rem_q == AW'(1));

   imem_loader_ctrl u_ctrl (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .count_zero_i (count_zero),
      .last_word_i  (last_word),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .xfer_o       (xfer),
      .accept_o     (accept),
      .busy_o       (busy),
      .done_o       (done),
      .cpu_hold_o   (cpu_hold)
   );

   // Write port goes straight to the instruction memory: zero-latency strobe.
   assign im_we    = xfer;
   assign im_addr  = addr_q;
   assign im_wdata = in_data;
   assign checksum = csum_q;

   always_comb begin
      addr_d = addr_q;
      rem_d  = rem_q;
      csum_d = csum_q;
      if (accept) begin
         addr_d = base_addr;
         rem_d  = word_count;
         csum_d = '0;
      end else if (xfer) begin
         addr_d = addr_q + AW'(1);
         rem_d  = rem_q - AW'(1);
         csum_d = csum_q + in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q <= '0;
         rem_q  <= '0;
         csum_q <= '0;
      end else begin
         addr_q <= addr_d;
         rem_q  <= rem_d;
         csum_q <= csum_d;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed table, hand sequences and randomized loads
// compared against an address/sum reference model.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] base_addr;
   logic [15:0] word_count;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_ready;
   logic        im_we;
   logic [15:0] im_addr;
   logic [15:0] im_wdata;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic [15:0] checksum;

   int n_err = 0;
   int n_chk = 0;

   logic [15:0] stim_q[$];
   logic [15:0] wr_addr_q[$];
   logic [15:0] wr_data_q[$];
   int          wr_cyc_q[$];
   int          cyc = 0;
   int          done_cnt = 0;
   int          done_cyc = -1;
   logic [15:0] last_csum;

   typedef struct {
      logic [15:0] base;
      int          count;
      logic [15:0] w0;
      logic [15:0] step;
      int          gap;
      logic [15:0] exp_csum;
      logic [15:0] exp_last;
   } vec_t;
   vec_t vt[6];

   imem_loader dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .im_we      (im_we),
      .im_addr    (im_addr),
      .im_wdata   (im_wdata),
      .cpu_hold   (cpu_hold),
      .busy       (busy),
      .done       (done),
      .checksum   (checksum)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (im_we === 1'b1) begin
         wr_addr_q.push_back(im_addr);
         wr_data_q.push_back(im_wdata);
         wr_cyc_q.push_back(cyc);
      end
      if (done === 1'b1) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic clear_mon();
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_cyc_q.delete();
   endtask

   // Drives one load of stim_q and checks it against the reference model:
   // word i lands at (base+i) mod 2^16, checksum is the plain sum mod 2^16.
   task automatic run_load(input string nm, input logic [15:0] base, input int gap,
                           input int restart_at);
      int          cnt;
      int          sum;
      int          blow;
      int          d0;
      int          t_done;
      bit          ok;
      logic [15:0] exp_addr;
      cnt  = stim_q.size();
      sum  = 0;
      blow = 0;
      foreach (stim_q[i]) sum += int'(stim_q[i]);
      clear_mon();
      d0 = done_cnt;

      @(posedge clk); #1;
      start = 1'b1; base_addr = base; word_count = 16'(cnt);
      @(posedge clk); #1;
      start = 1'b0; base_addr = 16'($urandom); word_count = 16'($urandom);

      for (int i = 0; i < cnt; i++) begin
         in_valid = 1'b1;
         in_data  = stim_q[i];
         if (i == restart_at) begin
            start = 1'b1; base_addr = 16'h0500; word_count = 16'd7;
         end
         ok = 1'b0;
         for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (busy !== 1'b1) blow++;
            ok = (in_ready === 1'b1);
            @(posedge clk); #1;
            start = 1'b0;
         end
         check({nm, "/accept"}, 32'(ok), 32'd1);
         in_valid = 1'b0;
         in_data  = 16'($urandom);
         if (!ok) break;
         if (i < cnt - 1) begin
            repeat (gap) begin
               @(negedge clk);
               if (busy !== 1'b1) blow++;
               @(posedge clk); #1;
            end
         end
      end

      t_done = 10;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            t_done = t;
            break;
         end
         if (busy !== 1'b1) blow++;
      end
      check({nm, "/done_latency"}, 32'(t_done), 32'd0);
      check({nm, "/busy_in_done"}, 32'(busy), 32'd1);
      check({nm, "/hold_in_done"}, 32'(cpu_hold), 32'd1);

      @(negedge clk);
      check({nm, "/hold_after"}, 32'(cpu_hold), 32'd0);
      check({nm, "/busy_after"}, 32'(busy), 32'd0);
      check({nm, "/done_single"}, 32'(done), 32'd0);
      check({nm, "/ready_after"}, 32'(in_ready), 32'd0);
      check({nm, "/busy_lows"}, 32'(blow), 32'd0);

      repeat (2) @(negedge clk);
      check({nm, "/done_count"}, 32'(done_cnt - d0), 32'd1);
      check({nm, "/nwr"}, 32'(wr_addr_q.size()), 32'(cnt));
      for (int i = 0; i < cnt && i < wr_addr_q.size(); i++) begin
         exp_addr = base + 16'(i);
         check($sformatf("%s/addr%0d", nm, i), 32'(wr_addr_q[i]), 32'(exp_addr));
         check($sformatf("%s/data%0d", nm, i), 32'(wr_data_q[i]), 32'(stim_q[i]));
         if (gap == 0 && i > 0)
            check($sformatf("%s/b2b%0d", nm, i), 32'(wr_cyc_q[i] - wr_cyc_q[i-1]), 32'd1);
      end
      if (wr_cyc_q.size() > 0)
         check({nm, "/done_after_last"}, 32'(done_cyc - wr_cyc_q[wr_cyc_q.size()-1]), 32'd1);
      check({nm, "/checksum"}, 32'(checksum), 32'(sum & 32'hFFFF));
      last_csum = checksum;
   endtask

   initial begin
      int cnt;
      int d0;
      logic [15:0] w;

      rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
      in_valid = 1'b1; in_data = 16'h5A5A;

      @(negedge clk);
      check("rst/im_we", 32'(im_we), 32'd0);
      check("rst/in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("rst/busy", 32'(busy), 32'd0);
      check("rst/done", 32'(done), 32'd0);
      check("rst/cpu_hold", 32'(cpu_hold), 32'd1);
      check("rst/checksum", 32'(checksum), 32'd0);
      check("rst/im_we_idle", 32'(im_we), 32'd0);
      repeat (3) @(negedge clk);
      check("rst/hold_before_load", 32'(cpu_hold), 32'd1);

      // Table of directed loads with hand-computed checksums and final addresses.
      vt[0] = '{16'hFFFE, 3, 16'h1111, 16'h1111, 0, 16'h6666, 16'h0000};
      vt[1] = '{16'h0040, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000};
      vt[2] = '{16'h0100, 4, 16'h0001, 16'h0001, 2, 16'h000A, 16'h0103};
      vt[3] = '{16'h1234, 2, 16'h8000, 16'h0000, 0, 16'h0000, 16'h1235};
      vt[4] = '{16'h0000, 1, 16'hABCD, 16'h0000, 1, 16'hABCD, 16'h0000};
      vt[5] = '{16'h7FFF, 3, 16'hFFFF, 16'hFFFF, 0, 16'hFFFA, 16'h8001};
      for (int v = 0; v < 6; v++) begin
         stim_q.delete();
         w = vt[v].w0;
         for (int i = 0; i < vt[v].count; i++) begin
            stim_q.push_back(w);
            w = w + vt[v].step;
         end
         run_load($sformatf("vec%0d", v), vt[v].base, vt[v].gap, -1);
         check($sformatf("vec%0d/exp_csum", v), 32'(last_csum), 32'(vt[v].exp_csum));
         if (vt[v].count > 0 && wr_addr_q.size() > 0)
            check($sformatf("vec%0d/last_addr", v), 32'(wr_addr_q[wr_addr_q.size()-1]),
                  32'(vt[v].exp_last));
      end

      // 19 back-to-back words from address 0.
      stim_q = '{16'h0245, 16'h06C2, 16'h8204, 16'h1A3F, 16'h2B7C, 16'h00FF, 16'hF00D,
                 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F0F, 16'h7777, 16'h4321,
                 16'h8888, 16'hC0DE, 16'h0001, 16'hFFFF, 16'h9E00};
      run_load("seq19", 16'h0000, 0, -1);

      // A second start mid-load must not move the write pointer.
      stim_q = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
      run_load("restart", 16'h0200, 1, 1);

      // Reset after two of five words: abort, hold re-asserts, no done.
      clear_mon();
      d0 = done_cnt;
      @(posedge clk); #1;
      start = 1'b1; base_addr = 16'h0300; word_count = 16'd5;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_data = 16'h0100 + 16'(i);
         @(posedge clk); #1;
      end
      rst = 1'b1; in_valid = 1'b1; in_data = 16'hDEAD;
      @(negedge clk);
      check("abort/im_we_in_rst", 32'(im_we), 32'd0);
      check("abort/ready_in_rst", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("abort/busy", 32'(busy), 32'd0);
      check("abort/cpu_hold", 32'(cpu_hold), 32'd1);
      check("abort/checksum", 32'(checksum), 32'd0);
      check("abort/in_ready", 32'(in_ready), 32'd0);
      repeat (4) @(negedge clk);
      check("abort/hold_idle", 32'(cpu_hold), 32'd1);
      check("abort/no_done", 32'(done_cnt - d0), 32'd0);
      check("abort/nwr", 32'(wr_addr_q.size()), 32'd2);
      stim_q = '{16'h4242};
      run_load("after_abort", 16'h0010, 0, -1);

      // Randomized loads, occasionally with a stray start mid-load.
      for (int r = 0; r < 25; r++) begin
         stim_q.delete();
         cnt = $urandom_range(0, 12);
         for (int i = 0; i < cnt; i++) stim_q.push_back(16'($urandom));
         run_load($sformatf("rnd%0d", r), 16'($urandom), $urandom_range(0, 2),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : -1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: DW, default 16, instruction word width.
REQ-002 Parameter: AW, default 16, instruction memory address width (65536 words).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a load; sampled only in IDLE.
REQ-006 base_addr  input  AW  first IM address; latched on accepted start.
REQ-007 word_count  input  AW  number of words to load; latched on accepted start.
REQ-008 in_valid  input  1  source presents a program word.
REQ-009 in_data  input  DW  program word.
REQ-010 in_ready  output  1  loader accepts in_data this cycle.
REQ-011 im_we  output  1  IM write strobe.
REQ-012 im_addr  output  AW  IM write address.
REQ-013 im_wdata  output  DW  IM write data.
REQ-014 cpu_hold  output  1  holds processor fetch/pc while high.
REQ-015 busy  output  1  load in progress.
REQ-016 done  output  1  one-cycle pulse at load completion.
REQ-017 checksum  output  DW  mod-2^DW sum of words written in the last load.

Function
REQ-018 States: IDLE, LOAD, DONE; encoding in shared package.
REQ-019 IDLE: in_ready=0, busy=0; start=1 -> LOAD, latch base_addr into addr register, word_count into remaining counter, clear checksum.
REQ-020 IDLE with start=1 and word_count=0 -> DONE directly; no IM write.
REQ-021 LOAD: in_ready=1, busy=1.
REQ-022 Word transfer occurs when in_valid=1 and in_ready=1; im_we=1 that cycle (combinational, zero latency), im_addr=addr register, im_wdata=in_data.
REQ-023 im_we=0 in every cycle with no transfer; im_addr/im_wdata are don't-care then.
REQ-024 On transfer: addr increments by 1 modulo 2^AW (0xFFFF -> 0x0000), remaining decrements, checksum += in_data modulo 2^DW.
REQ-025 Transfer with remaining=1 -> DONE next cycle; in_ready=0 from DONE onward.
REQ-026 in_valid=0 in LOAD: stay in LOAD, no state change, no timeout.
REQ-027 DONE: done=1 for exactly one cycle, busy=1, then -> IDLE.
REQ-028 start asserted while not in IDLE is ignored; no latch, no restart.
REQ-029 cpu_hold=1 from reset until first DONE, and in LOAD and DONE; 0 in IDLE only after at least one completed load.
REQ-030 checksum holds its value in IDLE until the next accepted start.

Reset
REQ-031 rst=1 at a clock edge: state=IDLE, in_ready=0, im_we=0, busy=0, done=0, checksum=0, addr=0, remaining=0, cpu_hold=1, loaded-once flag cleared.
REQ-032 Reset mid-load aborts; IM words already written are not undone; cpu_hold stays 1 until a new load completes.
REQ-033 im_we=0 in the reset cycle even if in_valid=1.

Structure
REQ-034 Shared package holds state encoding, DW/AW defaults and IM depth constant, shared with the pipeline processor.
REQ-035 One sub-module, imem_loader_ctrl (FSM plus hold/done logic); datapath (addr, remaining, checksum) stays in top.
REQ-036 IM write port connects directly to the processor instruction memory write port; no internal buffering.

Verification
REQ-037 base=0x0000, count=19, words 0x0245,0x06C2,0x8204,...,0x9E00 back-to-back -> 19 writes at addr 0..18 on consecutive cycles, done one cycle after last, cpu_hold falls next cycle, checksum=16-bit sum of the 19 words.
REQ-038 start with count=0 -> no im_we, done pulse on the cycle after start, checksum=0x0000.
REQ-039 base=0xFFFE, count=3, words 0x1111,0x2222,0x3333 -> writes at 0xFFFE,0xFFFF,0x0000; checksum=0x6666.
REQ-040 count=4 with in_valid low 2 cycles between words -> exactly 4 writes, addresses contiguous, busy high throughout, no extra done.
REQ-041 rst pulsed after 2 of 5 words -> state IDLE, cpu_hold=1, done never pulses; new load count=1 completes normally.
REQ-042 start pulsed again mid-load with different base -> ignored; addresses continue from original base.
